// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: word type, boot address, NOP encoding
// and the fetch sequencing states.
package instruction_fetch_pkg;

    typedef logic [31:0] word_t;

    localparam word_t BOOT_ADDRESS = 32'h0000_0000;

    // addi x0,x0,0 -- presented to decode whenever a fetch faults
    localparam word_t DEFAULT_NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Multi-cycle instruction fetch: one req/ack read per accepted fetch_start, with
// misalignment and timeout faults. All outputs are registered.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter word_t       NOP_INSTRUCTION = DEFAULT_NOP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] instruction_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic        fetch_done,
    output logic        misaligned_fault,
    output logic        timeout_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t     state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             mem_req_next;
    word_t            mem_addr_next;
    word_t            instruction_next;
    logic             valid_next;
    logic             done_next;
    logic             misaligned_next;
    logic             timeout_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            mem_req           <= 1'b0;
            mem_addr          <= '0;
            instruction       <= NOP_INSTRUCTION;
            instruction_valid <= 1'b0;
            fetch_done        <= 1'b0;
            misaligned_fault  <= 1'b0;
            timeout_fault     <= 1'b0;
        end else begin
            state             <= state_next;
            count             <= count_next;
            mem_req           <= mem_req_next;
            mem_addr          <= mem_addr_next;
            instruction       <= instruction_next;
            instruction_valid <= valid_next;
            fetch_done        <= done_next;
            misaligned_fault  <= misaligned_next;
            timeout_fault     <= timeout_next;
        end
    end

    always_comb begin
        state_next       = state;
        count_next       = count;
        mem_req_next     = mem_req;
        mem_addr_next    = mem_addr;
        instruction_next = instruction;
        valid_next       = instruction_valid;
        done_next        = 1'b0;
        misaligned_next  = misaligned_fault;
        timeout_next     = timeout_fault;

        unique case (state)
            IDLE: begin
                if (fetch_start) begin
                    valid_next   = 1'b0;
                    timeout_next = 1'b0;
                    if (instruction_addr[1:0] != 2'b00) begin
                        misaligned_next  = 1'b1;
                        instruction_next = NOP_INSTRUCTION;
                        done_next        = 1'b1;
                    end else begin
                        misaligned_next = 1'b0;
                        mem_req_next    = 1'b1;
                        mem_addr_next   = instruction_addr;
                        count_next      = '0;
                        state_next      = WAIT;
                    end
                end
            end
            WAIT: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    instruction_next = mem_rdata;
                    valid_next       = 1'b1;
                    done_next        = 1'b1;
                    mem_req_next     = 1'b0;
                    state_next       = IDLE;
                end else if (count == LAST_COUNT) begin
                    timeout_next     = 1'b1;
                    instruction_next = NOP_INSTRUCTION;
                    valid_next       = 1'b0;
                    done_next        = 1'b1;
                    mem_req_next     = 1'b0;
                    state_next       = IDLE;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch (TIMEOUT_CYCLES=4): vector table, corner sequences
// and randomized fetches against a transaction-level reference model.
module tb_instruction_fetch;

    localparam int          T   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [31:0] instruction_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        fetch_done;
    logic        misaligned_fault;
    logic        timeout_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    instruction_fetch #(.TIMEOUT_CYCLES(T)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_start      (fetch_start),
        .instruction_addr (instruction_addr),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .instruction      (instruction),
        .instruction_valid(instruction_valid),
        .fetch_done       (fetch_done),
        .misaligned_fault (misaligned_fault),
        .timeout_fault    (timeout_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          ack_cycle;   // request cycle carrying the ack, 0 = never
        logic [31:0] rdata;
        int          exp_reqs;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_mis;
        logic        exp_to;
        int          exp_lat;     // cycles from start edge to fetch_done
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one fetch, acknowledging on request cycle ack_cycle; observes a fixed window.
    task automatic do_fetch(input logic [31:0] a, input int ack_cycle, input logic [31:0] rd,
                            output int reqs, output int dones, output int lat, output int addr_bad);
        reqs = 0; dones = 0; lat = -1; addr_bad = 0;
        instruction_addr = a;
        fetch_start      = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                reqs++;
                if (mem_addr !== a) addr_bad++;
                mem_ack   = (reqs == ack_cycle);
                mem_rdata = rd;
            end
            if (fetch_done) begin
                dones++;
                if (lat < 0) lat = c;
            end
            step();
        end
        mem_ack = 1'b0;
    endtask

    // Reference: outcome of one fetch derived directly from the fetch rules.
    function automatic vec_t model(input logic [31:0] a, input int ack_cycle, input logic [31:0] rd);
        vec_t v;
        v.addr = a; v.ack_cycle = ack_cycle; v.rdata = rd;
        v.exp_mis = 1'b0; v.exp_to = 1'b0;
        if (a % 4 != 0) begin
            v.exp_reqs = 0; v.exp_instr = NOP; v.exp_valid = 1'b0; v.exp_mis = 1'b1; v.exp_lat = 1;
        end else if (ack_cycle >= 1 && ack_cycle <= T) begin
            v.exp_reqs = ack_cycle; v.exp_instr = rd; v.exp_valid = 1'b1; v.exp_lat = ack_cycle + 1;
        end else begin
            v.exp_reqs = T; v.exp_instr = NOP; v.exp_valid = 1'b0; v.exp_to = 1'b1; v.exp_lat = T + 1;
        end
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int reqs, dones, lat, addr_bad;
        do_fetch(v.addr, v.ack_cycle, v.rdata, reqs, dones, lat, addr_bad);
        check({tag, " req_cycles"}, reqs, v.exp_reqs);
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " mem_addr_stable"}, addr_bad, 0);
        check({tag, " instruction"}, instruction, v.exp_instr);
        check({tag, " valid"}, {31'd0, instruction_valid}, {31'd0, v.exp_valid});
        check({tag, " misaligned"}, {31'd0, misaligned_fault}, {31'd0, v.exp_mis});
        check({tag, " timeout"}, {31'd0, timeout_fault}, {31'd0, v.exp_to});
        check({tag, " req_idle"}, {31'd0, mem_req}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int dones;
        vecs[0] = '{32'h0000_0100, 3, 32'h0050_0093, 3, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 4};
        vecs[1] = '{32'h0000_0102, 0, 32'h1111_1111, 0, NOP,           1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{32'h0000_0200, 0, 32'h2222_2222, 4, NOP,           1'b0, 1'b0, 1'b1, 5};
        vecs[3] = '{32'h0000_0204, 4, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5};
        vecs[4] = '{32'h0000_0008, 1, 32'h1234_5678, 1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 2};
        vecs[5] = '{32'h0000_0301, 2, 32'h3333_3333, 0, NOP,           1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{32'h0000_0400, 5, 32'h4444_4444, 4, NOP,           1'b0, 1'b0, 1'b1, 5};

        reset = 1'b1; fetch_start = 1'b0; instruction_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset instruction", instruction, NOP);
        check("reset valid", {31'd0, instruction_valid}, 32'd0);
        check("reset done", {31'd0, fetch_done}, 32'd0);
        check("reset faults", {30'd0, misaligned_fault, timeout_fault}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Spurious ack while idle, then address change and fetch_start during WAIT.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        check("spurious done", {31'd0, fetch_done}, 32'd0);
        check("spurious req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0; instruction_addr = 32'h0000_0600; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("wait req", {31'd0, mem_req}, 32'd1);
        check("wait addr", mem_addr, 32'h0000_0600);
        instruction_addr = 32'h0000_0704; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("wait addr held", mem_addr, 32'h0000_0600);
        check("wait no early done", {31'd0, fetch_done}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        mem_ack = 1'b0;
        check("wait done", {31'd0, fetch_done}, 32'd1);
        check("wait instruction", instruction, 32'hCAFE_0001);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (fetch_done || mem_req) dones++;
        end
        check("wait extra activity", dones, 0);

        // Reset during WAIT, then a late ack.
        instruction_addr = 32'h0000_0800; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("rst-wait req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst-wait req dropped", {31'd0, mem_req}, 32'd0);
        check("rst-wait instruction", instruction, NOP);
        check("rst-wait valid", {31'd0, instruction_valid}, 32'd0);
        dones = 0;
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        for (int c = 0; c < 3; c++) begin
            step();
            if (fetch_done || mem_req || instruction_valid) dones++;
        end
        mem_ack = 1'b0;
        check("rst-wait late ack ignored", dones, 0);
        check("rst-wait instr kept", instruction, NOP);

        // Randomized fetches against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, r;
            int          ack;
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r   = $urandom();
            ack = $urandom_range(0, T + 1);
            run_vec($sformatf("rnd%0d", i), model(a, ack, r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
